// File: rtl/reg_writeback.sv
// Purpose : final writeback stage. Buffers memory-stage results in a 2-entry FIFO, drives the register file write port and keeps a busy scoreboard.
// Latency : result pushed at edge N drives rf_write_en in cycle N+1 when the FIFO was empty; it commits on the first later edge with rf_ready=1.
// Backpr. : in_ready drops only while both entries are held (from registered count); the head stays stable while rf_ready is low.
//
// Ports:
//   clk, reset (async, active-high)
//   in_*      : result from memory stage (valid/ready handshake)
//   rf_*      : register file write port (rf_ready acts as the write grant)
//   issue_*   : destination register of an issuing instruction -> sets busy
//   busy      : per-register pending-write scoreboard (bit 0 is always 0)
//   fwd_*     : writeback forwarding path, live only when WB_FORWARD_EN is defined
//
// Build option: define WB_FORWARD_EN to mirror the head write onto fwd_*; otherwise fwd_* are 0.

module reg_writeback #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_write,
    input  logic            in_mem_to_reg,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_load_data,
    input  logic            rf_ready,
    output logic            rf_write_en,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_write_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic [NREG-1:0] busy,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
);

    // FIFO storage, two slots addressed by 1-bit pointers
    logic [4:0]      r_rd   [2];
    logic            r_wr   [2];
    logic [XLEN-1:0] r_data [2];
    logic            r_wptr;
    logic            r_rptr;
    logic [1:0]      r_count;
    logic [NREG-1:0] r_busy;

    logic            w_push;
    logic            w_pop;
    logic            w_head_vld;
    logic            w_commit;
    logic [XLEN-1:0] w_load_ext;
    logic [XLEN-1:0] w_sel_data;
    logic [NREG-1:0] w_busy_set;
    logic [NREG-1:0] w_busy_clr;
    logic [NREG-1:0] w_busy_nxt;

    // Size/sign extension of the aligned load doubleword; 111 behaves as a full load
    always_comb begin
        w_load_ext = in_load_data;
        case (in_funct3)
            3'b000:  w_load_ext = {{(XLEN-8){in_load_data[7]}},   in_load_data[7:0]};
            3'b001:  w_load_ext = {{(XLEN-16){in_load_data[15]}}, in_load_data[15:0]};
            3'b010:  w_load_ext = {{(XLEN-32){in_load_data[31]}}, in_load_data[31:0]};
            3'b100:  w_load_ext = {{(XLEN-8){1'b0}},  in_load_data[7:0]};
            3'b101:  w_load_ext = {{(XLEN-16){1'b0}}, in_load_data[15:0]};
            3'b110:  w_load_ext = {{(XLEN-32){1'b0}}, in_load_data[31:0]};
            default: w_load_ext = in_load_data;
        endcase
    end

    assign w_sel_data = in_mem_to_reg ? w_load_ext : in_alu_result;

    assign in_ready   = (r_count != 2'd2);
    assign w_push     = in_valid && in_ready;
    assign w_head_vld = (r_count != 2'd0);

    // Non-writing entries drain without waiting for the register file
    assign w_pop      = w_head_vld && (!r_wr[r_rptr] || rf_ready);

    assign rf_write_en   = w_head_vld && r_wr[r_rptr];
    assign rf_rd         = w_head_vld ? r_rd[r_rptr]   : 5'd0;
    assign rf_write_data = w_head_vld ? r_data[r_rptr] : '0;
    assign w_commit      = rf_write_en && rf_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_rd[i]   <= 5'd0;
                r_wr[i]   <= 1'b0;
                r_data[i] <= '0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_rd[r_wptr]   <= in_rd;
                r_wr[r_wptr]   <= in_reg_write && (in_rd != 5'd0);
                r_data[r_wptr] <= w_sel_data;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Scoreboard: set is applied after clear so an issue beats a same-cycle commit
    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (issue_valid && (issue_rd != 5'd0)) begin
            w_busy_set[issue_rd] = 1'b1;
        end
        if (w_commit) begin
            w_busy_clr[rf_rd] = 1'b1;
        end
        w_busy_nxt    = (r_busy & ~w_busy_clr) | w_busy_set;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy = r_busy;

`ifdef WB_FORWARD_EN
    assign fwd_valid = rf_write_en;
    assign fwd_rd    = rf_rd;
    assign fwd_data  = rf_write_data;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = 5'd0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Purpose : directed self-checking bench for reg_writeback.
// Latency : inputs driven 1 time unit after each rising edge; outputs sampled at the same point.
// Backpr. : exercises rf_ready low/high, full FIFO and mid-stream reset.

module tb_reg_writeback;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic [2:0]  in_funct3;
    logic [63:0] in_alu_result;
    logic [63:0] in_load_data;
    logic        rf_ready;
    logic        rf_write_en;
    logic [4:0]  rf_rd;
    logic [63:0] rf_write_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] busy;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;

    int n_vec;
    int n_err;

    reg_writeback #(.XLEN(64), .NREG(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .in_mem_to_reg (in_mem_to_reg),
        .in_funct3     (in_funct3),
        .in_alu_result (in_alu_result),
        .in_load_data  (in_load_data),
        .rf_ready      (rf_ready),
        .rf_write_en   (rf_write_en),
        .rf_rd         (rf_rd),
        .rf_write_data (rf_write_data),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .busy          (busy),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Forwarding outputs follow the head write only in the forwarding build
    task automatic chk_fwd(input string tag, input logic v, input logic [4:0] rd, input logic [63:0] d);
`ifdef WB_FORWARD_EN
        chk({tag, "_fv"}, {63'd0, fwd_valid}, {63'd0, v});
        chk({tag, "_frd"}, {59'd0, fwd_rd}, {59'd0, rd});
        chk({tag, "_fd"}, fwd_data, d);
`else
        chk({tag, "_fv"}, {63'd0, fwd_valid}, 64'd0);
        chk({tag, "_frd"}, {59'd0, fwd_rd}, 64'd0);
        chk({tag, "_fd"}, fwd_data, 64'd0);
        if (v && rd == 5'd31 && d == 64'd1) $display("note: unused forwarding expectation");
`endif
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_res(input logic [4:0] rd, input logic wr, input logic m2r,
                             input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] ld);
        in_valid      = 1'b1;
        in_rd         = rd;
        in_reg_write  = wr;
        in_mem_to_reg = m2r;
        in_funct3     = f3;
        in_alu_result = alu;
        in_load_data  = ld;
    endtask

    logic [2:0]  f3_tab  [8];
    logic [63:0] exp_tab [8];
    logic [63:0] ld_val;

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        in_valid = 1'b0; in_rd = 5'd0; in_reg_write = 1'b0; in_mem_to_reg = 1'b0;
        in_funct3 = 3'd0; in_alu_result = 64'd0; in_load_data = 64'd0;
        rf_ready = 1'b0; issue_valid = 1'b0; issue_rd = 5'd0;

        ld_val = 64'h0123_4567_89AB_FF80;
        f3_tab[0] = 3'b000; exp_tab[0] = 64'hFFFF_FFFF_FFFF_FF80;
        f3_tab[1] = 3'b100; exp_tab[1] = 64'h0000_0000_0000_0080;
        f3_tab[2] = 3'b001; exp_tab[2] = 64'hFFFF_FFFF_FFFF_FF80;
        f3_tab[3] = 3'b101; exp_tab[3] = 64'h0000_0000_0000_FF80;
        f3_tab[4] = 3'b010; exp_tab[4] = 64'hFFFF_FFFF_89AB_FF80;
        f3_tab[5] = 3'b110; exp_tab[5] = 64'h0000_0000_89AB_FF80;
        f3_tab[6] = 3'b011; exp_tab[6] = 64'h0123_4567_89AB_FF80;
        f3_tab[7] = 3'b111; exp_tab[7] = 64'h0123_4567_89AB_FF80;

        // Reset state
        tick; tick;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_wen", {63'd0, rf_write_en}, 64'd0);
        chk("rst_rd", {59'd0, rf_rd}, 64'd0);
        chk("rst_data", rf_write_data, 64'd0);
        chk("rst_busy", {32'd0, busy}, 64'd0);
        chk_fwd("rst", 1'b0, 5'd0, 64'd0);
        reset = 1'b0;
        tick;

        // ALU result, one cycle after push
        rf_ready = 1'b1;
        drive_res(5'd5, 1'b1, 1'b0, 3'b000, 64'h1234, 64'hAAAA);
        tick;
        in_valid = 1'b0;
        chk("alu_wen", {63'd0, rf_write_en}, 64'd1);
        chk("alu_rd", {59'd0, rf_rd}, 64'd5);
        chk("alu_data", rf_write_data, 64'h1234);
        chk_fwd("alu", 1'b1, 5'd5, 64'h1234);
        tick;
        chk("alu_drained", {63'd0, rf_write_en}, 64'd0);

        // Load extension table
        for (int i = 0; i < 8; i++) begin
            drive_res(5'd10, 1'b1, 1'b1, f3_tab[i], 64'hDEAD_BEEF, ld_val);
            tick;
            in_valid = 1'b0;
            chk($sformatf("load_f3_%0d", f3_tab[i]), rf_write_data, exp_tab[i]);
            tick;
        end

        // Back-to-back pushes with rf_ready high: one commit per cycle
        for (int i = 0; i < 3; i++) begin
            drive_res(5'(11 + i), 1'b1, 1'b0, 3'b000, 64'(16'hB000 + i), 64'd0);
            tick;
            chk($sformatf("thru_rd_%0d", i), {59'd0, rf_rd}, 64'(11 + i));
            chk($sformatf("thru_data_%0d", i), rf_write_data, 64'(16'hB000 + i));
            chk($sformatf("thru_rdy_%0d", i), {63'd0, in_ready}, 64'd1);
        end
        in_valid = 1'b0;
        tick;
        chk("thru_empty", {63'd0, rf_write_en}, 64'd0);

        // Backpressure: two entries held, then drained on consecutive edges
        rf_ready = 1'b0;
        drive_res(5'd3, 1'b1, 1'b0, 3'b000, 64'h33, 64'd0);
        tick;
        drive_res(5'd4, 1'b1, 1'b0, 3'b000, 64'h44, 64'd0);
        tick;
        in_valid = 1'b0;
        chk("bp_full", {63'd0, in_ready}, 64'd0);
        chk("bp_head_rd", {59'd0, rf_rd}, 64'd3);
        chk("bp_head_data", rf_write_data, 64'h33);
        tick;
        chk("bp_hold_rd", {59'd0, rf_rd}, 64'd3);
        chk("bp_hold_wen", {63'd0, rf_write_en}, 64'd1);
        rf_ready = 1'b1;
        tick;
        chk("bp_second_rd", {59'd0, rf_rd}, 64'd4);
        chk("bp_second_data", rf_write_data, 64'h44);
        chk("bp_ready_back", {63'd0, in_ready}, 64'd1);
        tick;
        chk("bp_drained", {63'd0, rf_write_en}, 64'd0);

        // rd=0 retires in one cycle without writing, even with rf_ready low
        rf_ready = 1'b0;
        drive_res(5'd0, 1'b1, 1'b0, 3'b000, 64'h55, 64'd0);
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick;
        issue_valid = 1'b0;
        chk("x0_wen", {63'd0, rf_write_en}, 64'd0);
        chk("x0_busy", {32'd0, busy}, 64'd0);
        drive_res(5'd6, 1'b1, 1'b0, 3'b000, 64'h66, 64'd0);
        tick;
        in_valid = 1'b0;
        chk("x0_next_wen", {63'd0, rf_write_en}, 64'd1);
        chk("x0_next_rd", {59'd0, rf_rd}, 64'd6);
        chk("x0_next_rdy", {63'd0, in_ready}, 64'd1);
        rf_ready = 1'b1;
        tick;
        chk("x0_drained", {63'd0, rf_write_en}, 64'd0);

        // Scoreboard
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick;
        issue_valid = 1'b0;
        chk("sb_set", {32'd0, busy}, 64'h80);
        drive_res(5'd7, 1'b1, 1'b0, 3'b000, 64'h77, 64'd0);
        tick;
        in_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick;
        issue_valid = 1'b0;
        chk("sb_set_wins", {32'd0, busy}, 64'h80);
        drive_res(5'd7, 1'b1, 1'b0, 3'b000, 64'h78, 64'd0);
        tick;
        in_valid = 1'b0;
        chk("sb_pending", {32'd0, busy}, 64'h80);
        tick;
        chk("sb_clear", {32'd0, busy}, 64'h0);

        // Reset mid-stream with two entries buffered
        rf_ready = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd9;
        drive_res(5'd20, 1'b1, 1'b0, 3'b000, 64'h2020, 64'd0);
        tick;
        issue_valid = 1'b0;
        drive_res(5'd21, 1'b1, 1'b0, 3'b000, 64'h2121, 64'd0);
        tick;
        in_valid = 1'b0;
        chk("mr_full", {63'd0, in_ready}, 64'd0);
        chk("mr_busy_pre", {32'd0, busy}, 64'h200);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_wen", {63'd0, rf_write_en}, 64'd0);
        chk("mr_rdy", {63'd0, in_ready}, 64'd1);
        chk("mr_busy", {32'd0, busy}, 64'd0);
        chk("mr_rd", {59'd0, rf_rd}, 64'd0);
        chk_fwd("mr", 1'b0, 5'd0, 64'd0);
        tick;
        reset = 1'b0;
        rf_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("mr_nowrite_%0d", i), {63'd0, rf_write_en}, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
